// File: rtl/hand_tracker.sv
// hand_tracker: turns a proximity sensor stream into a filtered LCD x position, velocity and direction.
// Optional build macro HAND_TRACKER_AVG_EN selects a 4-tap moving-average filter; otherwise samples pass straight through.
module hand_tracker #(
  parameter logic [23:0] LOST_TIMEOUT = 24'd12_000_000,
  parameter logic [15:0] PROX_MAX     = 16'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dat_valid,
  input  logic [15:0] prox_dat,
  output logic [8:0]  handline,
  output logic [7:0]  hand_velocity,
  output logic        hand_dir,
  output logic        hand_valid,
  output logic        hand_lost,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, FILT, MAP, VEL} state_t;

  state_t             state, state_next;
  logic               dv_q;
  logic               armed;
  logic               rise;
  logic               accept;
  logic [15:0]        sample_q;
  logic               first_q;
  logic [9:0]         clamped;
  logic [9:0]         filt_next;
  logic [9:0]         filtered_q;
  logic [12:0]        scaled;
  logic [8:0]         pos;
  logic signed [9:0]  delta;
  logic [9:0]         mag;
  logic [7:0]         vel_sat;
  logic [23:0]        cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_next = state;
    rise       = dat_valid && !dv_q && armed;
    accept     = rise && (state == IDLE);
    case (state)
      IDLE:    if (accept) state_next = FILT;
      FILT:    state_next = MAP;
      MAP:     state_next = VEL;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clamped = (sample_q > PROX_MAX) ? PROX_MAX[9:0] : sample_q[9:0];
    scaled  = (13'(filtered_q) * 13'd5) >> 4;
    pos     = (scaled > 13'd319) ? 9'd319 : scaled[8:0];
    delta   = $signed({1'b0, pos}) - $signed({1'b0, handline});
    mag     = delta[9] ? -delta : delta;
    vel_sat = (mag > 10'd255) ? 8'd255 : mag[7:0];
    if (accept)                     cnt_next = '0;
    else if (cnt == LOST_TIMEOUT)   cnt_next = cnt;
    else                            cnt_next = cnt + 24'd1;
  end

`ifdef HAND_TRACKER_AVG_EN
  // Three history registers plus the sample being filtered form the four taps.
  logic [9:0]  hist [3];
  logic [11:0] tap_sum;

  always_comb begin
    if (first_q) tap_sum = {clamped, 2'b00};
    else         tap_sum = 12'(clamped) + 12'(hist[0]) + 12'(hist[1]) + 12'(hist[2]);
  end

  assign filt_next = tap_sum[11:2];

  always_ff @(posedge clk) begin
    // NOTE: the history shapes later outputs, so it is reset explicitly instead of trusting power-up contents.
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] <= '0;
    end else if (state == FILT) begin
      if (first_q) begin
        for (int i = 0; i < 3; i++) hist[i] <= clamped;
      end else begin
        hist[0] <= clamped;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
      end
    end
  end
`else
  assign filt_next = clamped;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dv_q          <= 1'b0;
      armed         <= 1'b0;
      sample_q      <= '0;
      first_q       <= 1'b0;
      filtered_q    <= '0;
      cnt           <= '0;
      handline      <= '0;
      hand_velocity <= '0;
      hand_dir      <= 1'b0;
      hand_valid    <= 1'b0;
      hand_lost     <= 1'b1;
      overrun       <= 1'b0;
    end else begin
      dv_q       <= dat_valid;
      cnt        <= cnt_next;
      hand_valid <= (state == MAP);
      // A level still high out of reset must be seen low before it can form an edge.
      if (!dat_valid) armed <= 1'b1;
      if (rise && (state != IDLE)) overrun <= 1'b1;

      if (accept) begin
        sample_q  <= prox_dat;
        first_q   <= hand_lost;
        hand_lost <= 1'b0;
      end else if (cnt_next == LOST_TIMEOUT) begin
        hand_lost     <= 1'b1;
        hand_velocity <= '0;
      end

      if (state == FILT) filtered_q <= filt_next;

      if (state == MAP) begin
        handline <= pos;
        if (first_q) begin
          hand_velocity <= '0;
          hand_dir      <= 1'b0;
        end else begin
          hand_velocity <= vel_sat;
          hand_dir      <= !delta[9] && (delta != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_hand_tracker.sv
// tb_hand_tracker: random and directed stimulus for hand_tracker, checked every cycle against an event-level model.
module tb_hand_tracker;

  localparam int LT = 100;
  localparam int PM = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dat_valid;
  logic [15:0] prox_dat;
  logic [8:0]  handline;
  logic [7:0]  hand_velocity;
  logic        hand_dir;
  logic        hand_valid;
  logic        hand_lost;
  logic        overrun;

  hand_tracker #(
    .LOST_TIMEOUT (24'(LT)),
    .PROX_MAX     (16'(PM))
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dat_valid     (dat_valid),
    .prox_dat      (prox_dat),
    .handline      (handline),
    .hand_velocity (hand_velocity),
    .hand_dir      (hand_dir),
    .hand_valid    (hand_valid),
    .hand_lost     (hand_lost),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_seen = 0;

  // Reference model state: sample history, busy window, timers and expected outputs.
  int m_prev_v, m_armed, m_busy, m_due, m_since;
  int m_lost, m_overrun, m_handline, m_vel, m_dir, m_valid;
  int p_line, p_vel, p_dir;
`ifdef HAND_TRACKER_AVG_EN
  int m_hist[$];
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_v = 0; m_armed = 0; m_busy = 0; m_due = 0; m_since = 0;
    m_lost = 1; m_overrun = 0; m_handline = 0; m_vel = 0; m_dir = 0; m_valid = 0;
`ifdef HAND_TRACKER_AVG_EN
    m_hist = '{0, 0, 0, 0};
`endif
  endtask

  task automatic model_step();
    int rise, acc, c, f, pos, dd, first;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise = (dat_valid && !m_prev_v && m_armed) ? 1 : 0;
    if (!dat_valid) m_armed = 1;
    m_prev_v = dat_valid ? 1 : 0;
    acc = 0;
    if (rise != 0) begin
      if (m_busy == 0) acc = 1;
      else             m_overrun = 1;
    end
    m_valid = 0;
    if (acc != 0) begin
      first = m_lost;
      c = (int'(prox_dat) > PM) ? PM : int'(prox_dat);
`ifdef HAND_TRACKER_AVG_EN
      if (first != 0) m_hist = '{c, c, c, c};
      else begin
        m_hist.push_front(c);
        void'(m_hist.pop_back());
      end
      f = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`else
      f = c;
`endif
      pos = f * 5 / 16;
      if (pos > 319) pos = 319;
      dd = pos - m_handline;
      p_line = pos;
      p_dir  = (first == 0 && dd > 0) ? 1 : 0;
      if (dd < 0) dd = -dd;
      p_vel  = (first != 0) ? 0 : ((dd > 255) ? 255 : dd);
      m_busy = 3; m_due = 2; m_since = 0; m_lost = 0;
    end else begin
      if (m_busy > 0) m_busy--;
      if (m_since < LT) m_since++;
      if (m_since == LT) begin
        m_lost = 1;
        m_vel  = 0;
      end
      if (m_due > 0) begin
        m_due--;
        if (m_due == 0) begin
          m_handline = p_line; m_vel = p_vel; m_dir = p_dir; m_valid = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    if (hand_valid === 1'b1) valid_seen++;
    check("handline",      handline,      m_handline);
    check("hand_velocity", hand_velocity, m_vel);
    check("hand_dir",      hand_dir,      m_dir);
    check("hand_valid",    hand_valid,    m_valid);
    check("hand_lost",     hand_lost,     m_lost);
    check("overrun",       overrun,       m_overrun);
  endtask

  task automatic pulse(input logic [15:0] p);
    prox_dat  = p;
    dat_valid = 1'b1;
    tick();
    dat_valid = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    int vs;
    logic [15:0] p;
    int hi_len, lo_len;
    model_reset();
    rst_n = 1'b0; dat_valid = 1'b1; prox_dat = 16'd0;
    repeat (3) tick();
    check("rst_line", handline, 0);
    check("rst_lost", hand_lost, 1);
    rst_n = 1'b1;
    repeat (4) tick();
    check("no_edge_at_release", valid_seen, 0);
    dat_valid = 1'b0;
    repeat (2) tick();

    pulse(16'd1023);
    check("s1_line", handline, 319);
    check("s1_vel", hand_velocity, 0);
    check("s1_dir", hand_dir, 0);
    check("s1_lost", hand_lost, 0);
    check("s1_strobes", valid_seen, 1);

    pulse(16'hFFFF);
    check("clamp_line", handline, 319);
    check("clamp_vel", hand_velocity, 0);
`ifndef HAND_TRACKER_AVG_EN
    pulse(16'd0);
    check("zero_line", handline, 0);
    check("zero_vel", hand_velocity, 255);
    check("zero_dir", hand_dir, 0);
    pulse(16'd500);
    check("up_line", handline, 156);
    check("up_vel", hand_velocity, 156);
    check("up_dir", hand_dir, 1);
`else
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    pulse(16'd0);    check("avg0", handline, 0);
    pulse(16'd1024); check("avg1", handline, 79);  check("avg1_vel", hand_velocity, 79);
    pulse(16'd1024); check("avg2", handline, 159); check("avg2_vel", hand_velocity, 80);
    pulse(16'd1024); check("avg3", handline, 239); check("avg3_vel", hand_velocity, 80);
    check("avg3_dir", hand_dir, 1);
`endif

    // Second edge two cycles after an accept.
    check("ovr_before", overrun, 0);
    vs = valid_seen;
    prox_dat = 16'd300; dat_valid = 1'b1; tick();
    dat_valid = 1'b0; tick();
    dat_valid = 1'b1; tick();
    dat_valid = 1'b0; repeat (6) tick();
    check("ovr_strobes", valid_seen - vs, 1);
    check("ovr_set", overrun, 1);
    pulse(16'd200);
    check("ovr_sticky", overrun, 1);

    // Timeout after a single accept.
    pulse(16'd600);
    repeat (94) tick();
    check("lost_early", hand_lost, 0);
    tick();
    check("lost_rise", hand_lost, 1);
    check("lost_hold", handline, m_handline);
    check("lost_vel", hand_velocity, 0);
    pulse(16'd100);
    check("relock_vel", hand_velocity, 0);
    check("relock_dir", hand_dir, 0);
    check("relock_lost", hand_lost, 0);

    // Reset during FILT aborts the sample.
    prox_dat = 16'd500; dat_valid = 1'b1; tick();
    rst_n = 1'b0; dat_valid = 1'b0; vs = valid_seen; tick();
    rst_n = 1'b1; repeat (5) tick();
    check("abort_strobes", valid_seen - vs, 0);
    check("abort_line", handline, 0);
    check("abort_vel", hand_velocity, 0);
    check("abort_dir", hand_dir, 0);
    check("abort_lost", hand_lost, 1);
    check("abort_ovr", overrun, 0);

    // Randomized bursts, including back-to-back edges, long gaps and resets.
    for (int b = 0; b < 300; b++) begin
      case ($urandom_range(0, 4))
        0:       p = 16'd0;
        1:       p = 16'd1023;
        2:       p = 16'hFFFF;
        3:       p = 16'($urandom_range(0, 1100));
        default: p = 16'($urandom);
      endcase
      hi_len = $urandom_range(1, 4);
      lo_len = ($urandom_range(0, 19) == 0) ? $urandom_range(95, 130) : $urandom_range(1, 6);
      prox_dat = p; dat_valid = 1'b1;
      repeat (hi_len) tick();
      dat_valid = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      repeat (lo_len) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
